// File: rtl/cache_controller_if.sv
// ============================================================================
// cache_controller_if : CPU-side and refill-side bus of the cache controller
// Rev 1.0
// ============================================================================
`default_nettype none

interface cache_controller_if;
  logic         cpu_req;
  logic [31:0]  cpu_addr;
  logic         flush;
  logic [31:0]  cpu_rdata;
  logic         cpu_ready;
  logic         busy;
  logic [31:0]  mem_addr;
  logic [127:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_addr, flush, mem_rdata,
    output cpu_rdata, cpu_ready, busy, mem_addr
  );

  modport master (
    output cpu_req, cpu_addr, flush, mem_rdata,
    input  cpu_rdata, cpu_ready, busy, mem_addr
  );
endinterface

`default_nettype wire

// File: rtl/cache_controller.sv
// ============================================================================
// cache_controller : direct-mapped read-only cache, 16-byte lines, fixed-latency refill
// Rev 1.0
// ============================================================================
`default_nettype none

module cache_controller #(
  parameter int MEM_LATENCY = 1,
  parameter int INDEX_BITS  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  cache_controller_if.slave   bus,
  output logic [15:0]         hit_count,
  output logic [15:0]         miss_count
);

  localparam int         LINES    = 1 << INDEX_BITS;
  localparam int         TAG_BITS = 32 - INDEX_BITS - 4;
  localparam logic [3:0] LATENCY  = 4'(MEM_LATENCY);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    FETCH  = 2'd2,
    FILL   = 2'd3
  } state_t;

  state_t                  state;
  logic [31:2]             req_addr;
  logic [LINES-1:0]        valid;
  logic [TAG_BITS-1:0]     tag_mem  [LINES];
  logic [127:0]            data_mem [LINES];
  logic [3:0]              wait_cnt;
  logic [31:0]             rdata;
  logic                    ready;
  logic [31:0]             maddr;
  logic [15:0]             hit_cnt;
  logic [15:0]             miss_cnt;

  logic [INDEX_BITS-1:0]   req_index;
  logic [TAG_BITS-1:0]     req_tag;
  logic [1:0]              req_word;
  logic                    line_hit;
  logic                    unused_addr_bits;

  assign req_index = req_addr[INDEX_BITS+3:4];
  assign req_tag   = req_addr[31:INDEX_BITS+4];
  assign req_word  = req_addr[3:2];
  assign line_hit  = valid[req_index] && (tag_mem[req_index] == req_tag);

  assign unused_addr_bits = ^bus.cpu_addr[1:0];

  assign bus.cpu_rdata = rdata;
  assign bus.cpu_ready = ready;
  assign bus.mem_addr  = maddr;
  assign bus.busy      = (state != IDLE);
  assign hit_count     = hit_cnt;
  assign miss_count    = miss_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      req_addr <= '0;
      valid    <= '0;
      wait_cnt <= '0;
      rdata    <= '0;
      ready    <= 1'b0;
      maddr    <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          // flush wins over a simultaneous request, which is dropped
          if (bus.flush) begin
            valid <= '0;
          end else if (bus.cpu_req) begin
            req_addr <= bus.cpu_addr[31:2];
            state    <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (line_hit) begin
            rdata <= data_mem[req_index][32*req_word +: 32];
            ready <= 1'b1;
            if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
            state <= IDLE;
          end else begin
            if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
            maddr    <= {req_addr[31:4], 4'b0000};
            wait_cnt <= LATENCY;
            state    <= FETCH;
          end
        end
        FETCH: begin
          if (wait_cnt <= 4'd1) begin
            wait_cnt <= '0;
            state    <= FILL;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        FILL: begin
          valid[req_index] <= 1'b1;
          rdata            <= bus.mem_rdata[32*req_word +: 32];
          ready            <= 1'b1;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Payload arrays are not reset; the valid bits alone gate their use.
  always_ff @(posedge clk) begin
    if (state == FILL) begin
      tag_mem[req_index]  <= req_tag;
      data_mem[req_index] <= bus.mem_rdata;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cache_controller.sv
// ============================================================================
// tb_cache_controller : directed self-checking bench, latency-1 and latency-3 instances
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cache_controller;

  logic clk = 1'b0;
  logic rst1_n = 1'b0;
  logic rst3_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc;

  logic [15:0] hc1, mc1, hc3, mc3;

  cache_controller_if b1 ();
  cache_controller_if b3 ();

  cache_controller #(.MEM_LATENCY(1), .INDEX_BITS(3)) dut1 (
    .clk(clk), .rst_n(rst1_n), .bus(b1), .hit_count(hc1), .miss_count(mc1)
  );
  cache_controller #(.MEM_LATENCY(3), .INDEX_BITS(3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .bus(b3), .hit_count(hc3), .miss_count(mc3)
  );

  always #5 clk = ~clk;

  // Memory model: word k of a line holds line base + 4k.
  assign b1.mem_rdata = {b1.mem_addr + 32'd12, b1.mem_addr + 32'd8, b1.mem_addr + 32'd4, b1.mem_addr};
  assign b3.mem_rdata = {b3.mem_addr + 32'd12, b3.mem_addr + 32'd8, b3.mem_addr + 32'd4, b3.mem_addr};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 1) ? b1.cpu_ready : b3.cpu_ready;
  endfunction

  // Drives one request; cycles counts edges from the accepting edge to cpu_ready.
  task automatic request(input int sel, input logic [31:0] addr, output int cycles);
    @(negedge clk);
    if (sel == 1) begin b1.cpu_req = 1'b1; b1.cpu_addr = addr; end
    else          begin b3.cpu_req = 1'b1; b3.cpu_addr = addr; end
    @(posedge clk); #1;
    cycles = 1;
    b1.cpu_req = 1'b0;
    b3.cpu_req = 1'b0;
    while (!rdy(sel) && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
    if (!rdy(sel)) cycles = 99;
  endtask

  initial begin
    b1.cpu_req = 1'b0; b1.cpu_addr = '0; b1.flush = 1'b0;
    b3.cpu_req = 1'b0; b3.cpu_addr = '0; b3.flush = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_ready",    {31'd0, b1.cpu_ready}, 32'd0);
    check("reset_rdata",    b1.cpu_rdata, 32'd0);
    check("reset_mem_addr", b1.mem_addr, 32'd0);
    check("reset_busy",     {31'd0, b1.busy}, 32'd0);
    check("reset_counts",   {hc1, mc1}, 32'd0);
    @(negedge clk);
    rst1_n = 1'b1;
    rst3_n = 1'b1;

    // Cold miss
    request(1, 32'h0000_0048, cyc);
    check("cold_latency",  cyc, 32'd4);
    check("cold_rdata",    b1.cpu_rdata, 32'h0000_0048);
    check("cold_mem_addr", b1.mem_addr, 32'h0000_0040);
    check("cold_miss_cnt", {16'd0, mc1}, 32'd1);

    // Hit on the filled line, issued back-to-back in the ready cycle
    request(1, 32'h0000_0044, cyc);
    check("hit_latency",  cyc, 32'd2);
    check("hit_rdata",    b1.cpu_rdata, 32'h0000_0044);
    check("hit_cnt",      {16'd0, hc1}, 32'd1);
    check("hit_mem_addr", b1.mem_addr, 32'h0000_0040);
    @(posedge clk); #1;
    check("ready_one_cycle", {31'd0, b1.cpu_ready}, 32'd0);
    check("rdata_hold",      b1.cpu_rdata, 32'h0000_0044);

    // Conflict on index 4
    request(1, 32'h0000_00C4, cyc);
    check("conf_latency",  cyc, 32'd4);
    check("conf_rdata",    b1.cpu_rdata, 32'h0000_00C4);
    check("conf_mem_addr", b1.mem_addr, 32'h0000_00C0);
    request(1, 32'h0000_0044, cyc);
    check("evict_latency", cyc, 32'd4);
    check("evict_rdata",   b1.cpu_rdata, 32'h0000_0044);
    check("evict_miss_cnt", {16'd0, mc1}, 32'd3);

    // Flush with a simultaneous request
    @(negedge clk);
    b1.flush = 1'b1; b1.cpu_req = 1'b1; b1.cpu_addr = 32'h0000_00C4;
    @(posedge clk); #1;
    check("flush_busy", {31'd0, b1.busy}, 32'd0);
    b1.flush = 1'b0; b1.cpu_req = 1'b0;
    @(posedge clk); #1;
    check("flush_busy_after", {31'd0, b1.busy}, 32'd0);
    check("flush_ready",      {31'd0, b1.cpu_ready}, 32'd0);
    request(1, 32'h0000_00C4, cyc);
    check("post_flush_latency", cyc, 32'd4);
    check("post_flush_miss_cnt", {16'd0, mc1}, 32'd4);

    // Hit counter saturation
    @(negedge clk);
    force dut1.hit_cnt = 16'hFFFE;
    request(1, 32'h0000_00C8, cyc);
    check("sat_hit1_rdata", b1.cpu_rdata, 32'h0000_00C8);
    @(negedge clk);
    release dut1.hit_cnt;
    request(1, 32'h0000_00CC, cyc);
    check("sat_hit2_rdata", b1.cpu_rdata, 32'h0000_00CC);
    request(1, 32'h0000_00C0, cyc);
    check("sat_hit3_latency", cyc, 32'd2);
    check("sat_hit_cnt", {16'd0, hc1}, 32'h0000_FFFF);
    check("sat_miss_cnt", {16'd0, mc1}, 32'd4);

    // Latency 3: reset during the second FETCH cycle
    @(negedge clk);
    b3.cpu_req = 1'b1; b3.cpu_addr = 32'h0000_1000;
    @(posedge clk); #1;
    b3.cpu_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("fetch_busy",     {31'd0, b3.busy}, 32'd1);
    check("fetch_mem_addr", b3.mem_addr, 32'h0000_1000);
    #1;
    rst3_n = 1'b0;
    #1;
    check("abort_busy",     {31'd0, b3.busy}, 32'd0);
    check("abort_mem_addr", b3.mem_addr, 32'd0);
    check("abort_ready",    {31'd0, b3.cpu_ready}, 32'd0);
    check("abort_rdata",    b3.cpu_rdata, 32'd0);
    check("abort_counts",   {hc3, mc3}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst3_n = 1'b1;
    request(3, 32'h0000_1000, cyc);
    check("lat3_latency", cyc, 32'd6);
    check("lat3_rdata",   b3.cpu_rdata, 32'h0000_1000);
    check("lat3_miss_cnt", {16'd0, mc3}, 32'd1);
    request(3, 32'h0000_100C, cyc);
    check("lat3_hit_latency", cyc, 32'd2);
    check("lat3_hit_rdata",   b3.cpu_rdata, 32'h0000_100C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
